// File: rtl/soc_fabric_pkg.sv
// soc_fabric_pkg: shared types and decode constants for the soc_mem_fabric
// native-bus interconnect (FSM state encoding, default error word, and
// address-window helpers).
package soc_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAM  = 2'd1,
    ST_SLV  = 2'd2,
    ST_RESP = 2'd3
  } fabric_state_e;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  // Slave windows are selected by the top address byte.
  localparam int SLAVE_SHIFT = 24;

  // First byte address past the internal SRAM (33 bits so a full 4 GiB RAM
  // would not wrap).
  function automatic logic [32:0] ram_top(input int unsigned words);
    return 33'(words) << 2;
  endfunction

endpackage

// File: rtl/soc_mem_fabric_if.sv
// soc_mem_fabric_if: CPU native bus plus peripheral fan-out bus of the
// memory fabric, with modports for the fabric (slave) and its environment
// (master: CPU and peripherals).
//
// Handshake: the CPU holds mem_valid with stable addr/wdata/wstrb until it
// sees the one-cycle mem_ready pulse; mem_rdata is meaningful only while
// mem_ready=1. Towards peripherals, s_valid is one-hot and s_addr/s_wdata/
// s_wstrb are stable while it is high; the selected slave finishes by
// raising its s_ready bit for one cycle with s_rdata slice valid.
interface soc_mem_fabric_if #(
  parameter int NUM_SLAVES = 4
) ();
  logic                       mem_valid;
  logic                       mem_instr;
  logic [31:0]                mem_addr;
  logic [31:0]                mem_wdata;
  logic [3:0]                 mem_wstrb;
  logic                       mem_ready;
  logic [31:0]                mem_rdata;
  logic [NUM_SLAVES-1:0]      s_valid;
  logic [NUM_SLAVES-1:0]      s_ready;
  logic [31:0]                s_addr;
  logic [31:0]                s_wdata;
  logic [3:0]                 s_wstrb;
  logic [32*NUM_SLAVES-1:0]   s_rdata;
  logic                       err_pulse;
  logic [31:0]                err_addr;

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  s_ready, s_rdata,
    output mem_ready, mem_rdata,
    output s_valid, s_addr, s_wdata, s_wstrb,
    output err_pulse, err_addr
  );

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output s_ready, s_rdata,
    input  mem_ready, mem_rdata,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    input  err_pulse, err_addr
  );
endinterface

// File: rtl/soc_fabric_ram.sv
// soc_fabric_ram: single-port SRAM, 32-bit words, per-byte write enables,
// synchronous read-first output. No reset so it maps onto a block RAM.
module soc_fabric_ram #(
  parameter int WORDS = 2048,
  parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_q;

  // Read the old word and merge the strobed bytes in the same enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_q <= r_mem[i_addr];
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/soc_mem_fabric.sv
// soc_mem_fabric: decodes PicoRV32 native-bus requests to an internal SRAM
// and NUM_SLAVES external peripheral windows, with registered responses and
// an error word for unmapped addresses.
// Optional watchdog on slave accesses: define SOC_FABRIC_TIMEOUT_EN.
module soc_mem_fabric
  import soc_fabric_pkg::*;
#(
  parameter int          RAM_WORDS      = 2048,
  parameter int          NUM_SLAVES     = 4,
  parameter logic [7:0]  SLAVE_BASE     = 8'h03,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  soc_mem_fabric_if.slave  bus,
  output fabric_state_e    o_state
);

  localparam logic [32:0] RAM_TOP = ram_top(RAM_WORDS);
  localparam int          RAM_AW  = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  fabric_state_e         r_state;
  fabric_state_e         w_next;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [NUM_SLAVES-1:0] r_sel_oh;
  logic [31:0]           r_rdata;
  logic                  r_ram_src;
  logic                  r_err;
  logic [31:0]           r_err_addr;

  logic [7:0]            w_win;
  logic [NUM_SLAVES-1:0] w_dec_oh;
  logic                  w_hit_ram;
  logic                  w_hit_slv;
  logic                  w_slv_done;
  logic [31:0]           w_slv_rdata;
  logic                  w_timeout;
  logic                  w_mem_ready;
  logic                  w_err_pulse;
  logic [NUM_SLAVES-1:0] w_s_valid;
  logic                  w_ram_en;
  logic [31:0]           w_ram_q;
  logic                  w_unused;

  assign w_win     = bus.mem_addr[31:SLAVE_SHIFT];
  assign w_hit_ram = ({1'b0, bus.mem_addr} < RAM_TOP);
  assign w_hit_slv = |w_dec_oh;

  // Slave window decode; compared as integers so windows never wrap past 8'hFF.
  always_comb begin
    w_dec_oh = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(w_win) == int'(SLAVE_BASE) + i) w_dec_oh[i] = 1'b1;
    end
  end

  // Completion and read-data select for the slave latched at accept time.
  always_comb begin
    w_slv_done  = |(bus.s_ready & r_sel_oh) && (r_state == ST_SLV);
    w_slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel_oh[i]) w_slv_rdata = w_slv_rdata | bus.s_rdata[32*i +: 32];
    end
  end

`ifdef SOC_FABRIC_TIMEOUT_EN
  logic [15:0] r_cnt;

  // Watchdog: armed while idle, counts down during SLV; expiry at 1 means
  // this is the last SLV cycle, and a same-cycle s_ready still wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= 16'(TIMEOUT_CYCLES);
    end else if (r_state == ST_SLV && r_cnt != 16'd0) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign w_timeout = (r_state == ST_SLV) && !w_slv_done && (r_cnt <= 16'd1);
  assign w_unused  = bus.mem_instr;
`else
  assign w_timeout = 1'b0;
  assign w_unused  = bus.mem_instr ^ (^32'(TIMEOUT_CYCLES));
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and bus strobes. Unmapped requests pass through the RAM slot
  // with the SRAM held off so every non-slave access has the same latency.
  always_comb begin
    w_next      = r_state;
    w_mem_ready = 1'b0;
    w_err_pulse = 1'b0;
    w_s_valid   = '0;
    w_ram_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          if (!w_hit_ram && w_hit_slv) w_next = ST_SLV;
          else                         w_next = ST_RAM;
        end
      end
      ST_RAM: begin
        w_ram_en = !r_err;
        w_next   = ST_RESP;
      end
      ST_SLV: begin
        w_s_valid = r_sel_oh;
        if (w_slv_done || w_timeout) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_mem_ready = 1'b1;
        w_err_pulse = r_err;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, response data and error bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_sel_oh   <= '0;
      r_rdata    <= '0;
      r_ram_src  <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.mem_valid) begin
            r_addr    <= bus.mem_addr;
            r_wdata   <= bus.mem_wdata;
            r_wstrb   <= bus.mem_wstrb;
            r_ram_src <= w_hit_ram;
            r_sel_oh  <= w_hit_ram ? '0 : w_dec_oh;
            r_err     <= !w_hit_ram && !w_hit_slv;
            if (!w_hit_ram && !w_hit_slv) begin
              r_rdata    <= ERR_RDATA;
              r_err_addr <= bus.mem_addr;
            end
          end
        end
        ST_SLV: begin
          if (w_slv_done) begin
            r_rdata <= w_slv_rdata;
          end else if (w_timeout) begin
            r_rdata    <= ERR_RDATA;
            r_err      <= 1'b1;
            r_err_addr <= r_addr;
          end
        end
        default: ;
      endcase
    end
  end

  soc_fabric_ram #(
    .WORDS (RAM_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .i_clk   (clk),
    .i_en    (w_ram_en),
    .i_we    (r_wstrb),
    .i_addr  (r_addr[RAM_AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  assign bus.mem_ready = w_mem_ready;
  assign bus.mem_rdata = r_ram_src ? w_ram_q : r_rdata;
  assign bus.s_valid   = w_s_valid;
  assign bus.s_addr    = r_addr;
  assign bus.s_wdata   = r_wdata;
  assign bus.s_wstrb   = r_wstrb;
  assign bus.err_pulse = w_err_pulse;
  assign bus.err_addr  = r_err_addr;
  assign o_state       = r_state;

endmodule

// File: tb/tb_soc_mem_fabric.sv
// tb_soc_mem_fabric: self-checking bench for soc_mem_fabric with a CPU
// driver, an in-bench peripheral responder and a behavioural memory map model.
module tb_soc_mem_fabric;
  import soc_fabric_pkg::*;

  localparam int          RAM_WORDS = 2048;
  localparam int          NS        = 4;
  localparam logic [7:0]  SB        = 8'h03;
  localparam logic [31:0] ERRW      = 32'hDEAD_BEEF;
  localparam int          TMO       = 8;

  typedef struct {
    int              rdy_cyc;
    logic [31:0]     rdata;
    int              err_cnt;
    logic [NS-1:0]   sv_seen;
    int              sv_cyc;
    logic [31:0]     sa;
    logic [31:0]     sd;
    logic [3:0]      ss;
    logic            pre_rdy;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  fabric_state_e dbg_state;
  int            n_checks = 0;
  int            n_err = 0;
  logic [31:0]   mdl_ram [int];

  soc_mem_fabric_if #(.NUM_SLAVES(NS)) bus ();

  soc_mem_fabric #(
    .RAM_WORDS      (RAM_WORDS),
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (SB),
    .ERR_RDATA      (ERRW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- reference model ----------------
  // 0 = RAM, 1 = slave (sidx set), 2 = unmapped
  function automatic int region(input logic [31:0] a, output int sidx);
    sidx = int'(a[31:24]) - int'(SB);
    if (a < 32'(4 * RAM_WORDS)) return 0;
    if (sidx >= 0 && sidx < NS) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (st[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  // ---------------- driver ----------------
  // One CPU access. slv<0: no slave responder; lat<0: slave never ready;
  // otherwise slave raises s_ready lat cycles after s_valid first appears.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int slv, input int lat,
                           input logic [31:0] srd, input bit drop, output obs_t o);
    int c;
    o.rdy_cyc = -1; o.rdata = '0; o.err_cnt = 0; o.sv_seen = '0; o.sv_cyc = 0;
    o.sa = '0; o.sd = '0; o.ss = '0;
    @(negedge clk);
    o.pre_rdy = bus.mem_ready;
    bus.mem_valid = 1'b1;
    bus.mem_instr = 1'($urandom);
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    for (int i = 0; i < NS; i++) bus.s_rdata[32*i +: 32] = $urandom;
    bus.s_ready = NS'($urandom);
    if (slv >= 0) begin
      bus.s_rdata[32*slv +: 32] = srd;
      bus.s_ready[slv] = 1'b0;
    end
    c = 0;
    while (c < 300) begin
      @(negedge clk);
      c++;
      if (bus.err_pulse) o.err_cnt++;
      if (bus.s_valid != '0) begin
        o.sv_seen = o.sv_seen | bus.s_valid;
        o.sv_cyc++;
        o.sa = bus.s_addr; o.sd = bus.s_wdata; o.ss = bus.s_wstrb;
      end
      if (bus.mem_ready) begin
        o.rdy_cyc = c;
        o.rdata = bus.mem_rdata;
        break;
      end
      if (drop && c == 1) begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = $urandom;
        bus.mem_wdata = $urandom;
      end
      bus.s_ready = NS'($urandom);
      if (slv >= 0) bus.s_ready[slv] = (lat >= 0 && c == 1 + lat);
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    bus.s_ready   = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus.mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_mem_ready: got %b want 0", bus.mem_ready); end
    n_checks++; if (bus.mem_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_rdata: got %h want 0", bus.mem_rdata); end
    n_checks++; if (bus.s_valid !== '0) begin n_err++; $display("FAIL rst_s_valid: got %b want 0", bus.s_valid); end
    n_checks++; if ({bus.s_addr, bus.s_wdata, bus.s_wstrb} !== 68'h0) begin n_err++; $display("FAIL rst_s_bus: got %h %h %h want 0", bus.s_addr, bus.s_wdata, bus.s_wstrb); end
    n_checks++; if (bus.err_pulse !== 1'b0) begin n_err++; $display("FAIL rst_err_pulse: got %b want 0", bus.err_pulse); end
    n_checks++; if (bus.err_addr !== 32'h0) begin n_err++; $display("FAIL rst_err_addr: got %h want 0", bus.err_addr); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_ram_basic();
    obs_t o;
    do_access(32'h10, 32'h1234_5678, 4'hF, -1, 0, 0, 1'b0, o);
    mdl_ram[4] = 32'h1234_5678;
    n_checks++; if (o.rdy_cyc !== 2) begin n_err++; $display("FAIL ram_wr_latency: got %0d want 2", o.rdy_cyc); end
    do_access(32'h10, 32'h0, 4'h0, -1, 0, 0, 1'b0, o);
    n_checks++; if (o.rdy_cyc !== 2) begin n_err++; $display("FAIL ram_rd_latency: got %0d want 2", o.rdy_cyc); end
    n_checks++; if (o.rdata !== 32'h1234_5678) begin n_err++; $display("FAIL ram_rd_data: got %h want 12345678", o.rdata); end
    do_access(32'h10, 32'hAABB_CCDD, 4'b0010, -1, 0, 0, 1'b0, o);
    n_checks++; if (o.rdata !== 32'h1234_5678) begin n_err++; $display("FAIL ram_read_first: got %h want 12345678", o.rdata); end
    mdl_ram[4] = merge(mdl_ram[4], 32'hAABB_CCDD, 4'b0010);
    do_access(32'h10, 32'h0, 4'h0, -1, 0, 0, 1'b0, o);
    n_checks++; if (o.rdata !== 32'h1234_CC78) begin n_err++; $display("FAIL ram_partial: got %h want 1234cc78", o.rdata); end
    n_checks++; if (o.err_cnt !== 0 || o.sv_seen !== '0) begin n_err++; $display("FAIL ram_side: got err=%0d sv=%b want 0 0", o.err_cnt, o.sv_seen); end
  endtask

  task automatic test_slave();
    obs_t o;
    do_access(32'h0500_0004, 32'h0, 4'h0, 2, 3, 32'hCAFE_0001, 1'b0, o);
    n_checks++; if (o.sv_seen !== 4'b0100) begin n_err++; $display("FAIL slv_onehot: got %b want 0100", o.sv_seen); end
    n_checks++; if (o.sa !== 32'h0500_0004) begin n_err++; $display("FAIL slv_addr: got %h want 05000004", o.sa); end
    n_checks++; if (o.sv_cyc !== 4) begin n_err++; $display("FAIL slv_valid_len: got %0d want 4", o.sv_cyc); end
    n_checks++; if (o.rdy_cyc !== 5) begin n_err++; $display("FAIL slv_latency: got %0d want 5", o.rdy_cyc); end
    n_checks++; if (o.rdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL slv_rdata: got %h want cafe0001", o.rdata); end
    n_checks++; if (o.err_cnt !== 0) begin n_err++; $display("FAIL slv_err: got %0d want 0", o.err_cnt); end
  endtask

  task automatic test_unmapped();
    obs_t o;
    logic [31:0] addrs [4];
    addrs[0] = 32'h0100_0000;
    addrs[1] = 32'(4 * RAM_WORDS);
    addrs[2] = {8'(SB + 8'(NS)), 24'h00_0010};
    addrs[3] = {8'(SB - 8'd1), 24'hFF_FFFC};
    for (int k = 0; k < 4; k++) begin
      do_access(addrs[k], 32'h5555_AAAA, (k == 1) ? 4'hF : 4'h0, -1, 0, 0, 1'b0, o);
      n_checks++; if (o.rdy_cyc !== 2) begin n_err++; $display("FAIL unm_latency[%0d]: got %0d want 2", k, o.rdy_cyc); end
      n_checks++; if (o.rdata !== ERRW) begin n_err++; $display("FAIL unm_rdata[%0d]: got %h want %h", k, o.rdata, ERRW); end
      n_checks++; if (o.err_cnt !== 1) begin n_err++; $display("FAIL unm_err_pulse[%0d]: got %0d want 1", k, o.err_cnt); end
      n_checks++; if (bus.err_addr !== addrs[k]) begin n_err++; $display("FAIL unm_err_addr[%0d]: got %h want %h", k, bus.err_addr, addrs[k]); end
    end
    // Write at RAM_TOP must not alias onto word 0.
    do_access(32'h0, 32'h0, 4'h0, -1, 0, 0, 1'b0, o);
    if (mdl_ram.exists(0)) begin
      n_checks++; if (o.rdata !== mdl_ram[0]) begin n_err++; $display("FAIL unm_no_alias: got %h want %h", o.rdata, mdl_ram[0]); end
    end
  endtask

  task automatic test_random();
    obs_t o;
    int words [8];
    int w, sidx, rg, lat;
    logic [31:0] a, wd, srd, expd;
    logic [3:0] st;
    bit drop;
    words = '{0, 1, 2, 3, 5, 6, RAM_WORDS - 2, RAM_WORDS - 1};
    for (int k = 0; k < 8; k++) begin
      wd = $urandom;
      do_access(32'(words[k] * 4), wd, 4'hF, -1, 0, 0, 1'b0, o);
      mdl_ram[words[k]] = wd;
      n_checks++; if (o.rdy_cyc !== 2) begin n_err++; $display("FAIL rnd_fill_latency: got %0d want 2", o.rdy_cyc); end
    end
    for (int n = 0; n < 40; n++) begin
      rg = $urandom_range(0, 3);
      wd = $urandom; srd = $urandom; lat = $urandom_range(0, 5);
      st = ($urandom_range(0, 1) == 1) ? 4'(($urandom)) : 4'h0;
      drop = ($urandom_range(0, 4) == 0);
      if (rg == 1) a = {8'(int'(SB) + $urandom_range(0, NS - 1)), 24'($urandom)};
      else if (rg == 2) begin
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a = {8'h00, 24'($urandom_range(4 * RAM_WORDS, 24'hFF_FFFF))};
        for (int t = 0; t < 20 && region(a, sidx) != 2; t++) a = $urandom;
      end else begin
        w = words[$urandom_range(0, 7)];
        a = 32'(w * 4);
      end
      rg = region(a, sidx);
      do_access(a, wd, st, (rg == 1) ? sidx : -1, lat, srd, drop, o);
      if (rg == 0) begin
        expd = mdl_ram[int'(a >> 2)];
        n_checks++; if (o.rdy_cyc !== 2 || o.rdata !== expd) begin n_err++; $display("FAIL rnd_ram[%0d] a=%h: got cyc=%0d data=%h want cyc=2 data=%h", n, a, o.rdy_cyc, o.rdata, expd); end
        n_checks++; if (o.err_cnt !== 0 || o.sv_seen !== '0) begin n_err++; $display("FAIL rnd_ram_side[%0d]: got err=%0d sv=%b want 0 0", n, o.err_cnt, o.sv_seen); end
        mdl_ram[int'(a >> 2)] = merge(expd, wd, st);
      end else if (rg == 1) begin
        n_checks++; if (o.rdy_cyc !== lat + 2 || o.rdata !== srd) begin n_err++; $display("FAIL rnd_slv[%0d] a=%h: got cyc=%0d data=%h want cyc=%0d data=%h", n, a, o.rdy_cyc, o.rdata, lat + 2, srd); end
        n_checks++; if (o.sv_seen !== NS'(1 << sidx) || o.sv_cyc !== lat + 1) begin n_err++; $display("FAIL rnd_slv_valid[%0d]: got sv=%b len=%0d want sv=%b len=%0d", n, o.sv_seen, o.sv_cyc, NS'(1 << sidx), lat + 1); end
        n_checks++; if (o.sa !== a || o.sd !== wd || o.ss !== st) begin n_err++; $display("FAIL rnd_slv_bus[%0d]: got %h %h %h want %h %h %h", n, o.sa, o.sd, o.ss, a, wd, st); end
        n_checks++; if (o.err_cnt !== 0) begin n_err++; $display("FAIL rnd_slv_err[%0d]: got %0d want 0", n, o.err_cnt); end
      end else begin
        n_checks++; if (o.rdy_cyc !== 2 || o.rdata !== ERRW) begin n_err++; $display("FAIL rnd_unm[%0d] a=%h: got cyc=%0d data=%h want cyc=2 data=%h", n, a, o.rdy_cyc, o.rdata, ERRW); end
        n_checks++; if (o.err_cnt !== 1 || bus.err_addr !== a || o.sv_seen !== '0) begin n_err++; $display("FAIL rnd_unm_err[%0d]: got pulses=%0d addr=%h sv=%b want 1 %h 0", n, o.err_cnt, bus.err_addr, o.sv_seen, a); end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [31:0] s1;
    int lat;
    s1 = $urandom; lat = $urandom_range(0, 2);
    do_access(32'h0, 32'h0, 4'h0, -1, 0, 0, 1'b0, o);
    n_checks++; if (o.rdy_cyc !== 2 || o.rdata !== mdl_ram[0]) begin n_err++; $display("FAIL b2b_ram0: got cyc=%0d data=%h want cyc=2 data=%h", o.rdy_cyc, o.rdata, mdl_ram[0]); end
    do_access(32'h0400_0008, 32'h0, 4'h0, 1, lat, s1, 1'b0, o);
    n_checks++; if (o.pre_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_pulse1: got ready=%b after RESP want 0", o.pre_rdy); end
    n_checks++; if (o.rdy_cyc !== lat + 2 || o.rdata !== s1 || o.sv_seen !== 4'b0010) begin n_err++; $display("FAIL b2b_slv1: got cyc=%0d data=%h sv=%b want cyc=%0d data=%h sv=0010", o.rdy_cyc, o.rdata, o.sv_seen, lat + 2, s1); end
    do_access(32'h4, 32'h0, 4'h0, -1, 0, 0, 1'b0, o);
    n_checks++; if (o.pre_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_pulse2: got ready=%b after RESP want 0", o.pre_rdy); end
    n_checks++; if (o.rdy_cyc !== 2 || o.rdata !== mdl_ram[1]) begin n_err++; $display("FAIL b2b_ram1: got cyc=%0d data=%h want cyc=2 data=%h", o.rdy_cyc, o.rdata, mdl_ram[1]); end
  endtask

  task automatic test_reset_mid_slv();
    obs_t o;
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h0300_0000; bus.mem_wstrb = 4'h0;
    bus.s_ready = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.s_valid !== 4'b0001) begin n_err++; $display("FAIL rmid_pre_valid: got %b want 0001", bus.s_valid); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.s_valid !== '0 || bus.mem_ready !== 1'b0 || bus.err_pulse !== 1'b0) begin n_err++; $display("FAIL rmid_async: got sv=%b rdy=%b err=%b want 0 0 0", bus.s_valid, bus.mem_ready, bus.err_pulse); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rmid_state: got %0d want IDLE", dbg_state); end
    bus.mem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_access(32'h10, 32'h0, 4'h0, -1, 0, 0, 1'b0, o);
    n_checks++; if (o.rdy_cyc !== 2 || o.rdata !== mdl_ram[4]) begin n_err++; $display("FAIL rmid_ram_after: got cyc=%0d data=%h want cyc=2 data=%h", o.rdy_cyc, o.rdata, mdl_ram[4]); end
  endtask

`ifdef SOC_FABRIC_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    do_access(32'h0300_0040, 32'h0, 4'h0, 0, -1, 32'h1111_2222, 1'b0, o);
    n_checks++; if (o.sv_cyc !== TMO) begin n_err++; $display("FAIL tmo_valid_len: got %0d want %0d", o.sv_cyc, TMO); end
    n_checks++; if (o.rdy_cyc !== TMO + 1 || o.rdata !== ERRW) begin n_err++; $display("FAIL tmo_resp: got cyc=%0d data=%h want cyc=%0d data=%h", o.rdy_cyc, o.rdata, TMO + 1, ERRW); end
    n_checks++; if (o.err_cnt !== 1 || bus.err_addr !== 32'h0300_0040) begin n_err++; $display("FAIL tmo_err: got pulses=%0d addr=%h want 1 03000040", o.err_cnt, bus.err_addr); end
    do_access(32'h0300_0044, 32'h0, 4'h0, 0, TMO - 1, 32'h1111_2222, 1'b0, o);
    n_checks++; if (o.rdy_cyc !== TMO + 1 || o.rdata !== 32'h1111_2222 || o.err_cnt !== 0) begin n_err++; $display("FAIL tmo_last_cycle: got cyc=%0d data=%h err=%0d want cyc=%0d data=11112222 err=0", o.rdy_cyc, o.rdata, o.err_cnt, TMO + 1); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = '0;
    bus.mem_wdata = '0;   bus.mem_wstrb = '0;   bus.s_ready = '0;
    bus.s_rdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_ram_basic();
    test_slave();
    test_unmapped();
    test_random();
    test_back_to_back();
    test_reset_mid_slv();
`ifdef SOC_FABRIC_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
